// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | Shared types for the 64-bit arithmetic datapath issue side.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int c_data_w = 64;

    // Opcode encoding doubles as the result-mux select and the unit bit index.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic [3:0] op_onehot(input op_e op);
        return 4'b0001 << op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_timeout_counter                                                        |
// | Down-counter bounding the wait for a functional unit's done.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_load;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_dispatch                                                               |
// | Issues one add/sub/mult/div at a time and returns the muxed result.        |
// | Optional WAIT timeout: define ALU_DISPATCH_TIMEOUT_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DATA_W         = c_data_w,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic [3:0]        unit_start,
    input  logic [3:0]        unit_done,
    output logic [1:0]        mux_select,
    input  logic [DATA_W-1:0] mux_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_op,
    output logic              rsp_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("alu_dispatch: TIMEOUT_CYCLES must be at least 2");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    logic [DATA_W-1:0] r_unit_a;
    logic [DATA_W-1:0] r_unit_b;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              w_div_zero;
    logic              w_done_sel;
    logic              w_expired;

    assign w_div_zero = (op_e'(req_op) == OP_DIV) && (req_b == '0);
    // Only the selected unit's done matters; others may be stale or stray.
    assign w_done_sel = unit_done[r_op];

`ifdef ALU_DISPATCH_TIMEOUT_EN
    logic w_cnt_expired;

    alu_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    ((r_state == ISSUE) && !w_done_sel),
        .enable  (r_state == WAIT),
        .expired (w_cnt_expired)
    );

    assign w_expired = (r_state == WAIT) && w_cnt_expired;
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_div_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = w_done_sel ? RESP : WAIT;
            end
            WAIT: begin
                if (w_done_sel || w_expired) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= OP_ADD;
            r_unit_a   <= '0;
            r_unit_b   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op     <= op_e'(req_op);
                        r_unit_a <= req_a;
                        r_unit_b <= req_b;
                        if (w_div_zero) begin
                            r_rsp_data <= '1;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    // Done takes priority over a simultaneous expiry.
                    if (w_done_sel) begin
                        r_rsp_data <= mux_result;
                        r_rsp_err  <= 1'b0;
                    end else if (w_expired) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign unit_start = (r_state == ISSUE) ? op_onehot(r_op) : 4'b0000;
    assign unit_a     = r_unit_a;
    assign unit_b     = r_unit_b;
    assign mux_select = r_op;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_op     = r_op;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire
